// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction prefetch queue sitting between instruction memory and decode.
//   Keeps its own fetch PC, issues one word request per cycle while it has
//   credit (queued entries plus the outstanding response stay below DEPTH),
//   and presents the oldest fetched word to decode with a valid/ready
//   handshake. A redirect flushes the queue and drops the in-flight response.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   fetch_en_i     permits new memory requests
//   im_req_o       memory request this cycle
//   im_addr_o      word-aligned fetch address, valid with im_req_o
//   im_dout_i      instruction word, returned one cycle after the request
//   redirect_i     flush and restart fetching at redirect_pc_i
//   redirect_pc_i  new fetch address (bits [1:0] ignored)
//   valid_o        head entry present
//   ready_i        decode accepts the head entry
//   inst_o         head instruction, NOP when empty
//   pc_o           head PC, 0 when empty
//   count_o        number of occupied entries
module fetch_queue #(
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         fetch_en_i,
    output logic                         im_req_o,
    output logic [XLEN-1:0]              im_addr_o,
    input  logic [31:0]                  im_dout_i,
    input  logic                         redirect_i,
    input  logic [XLEN-1:0]              redirect_pc_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [31:0]                  inst_o,
    output logic [XLEN-1:0]              pc_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              pend_q, pend_d;
    logic [XLEN-1:0]   pend_pc_q;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       inst_mem_q [DEPTH];
    logic [XLEN-1:0]   pc_mem_q   [DEPTH];

    logic              req;
    logic              push;
    logic              pop;
    logic [CW:0]       used;

    // Credit counts the outstanding response so a push can never overflow;
    // a pop in the same cycle is deliberately not credited.
    assign used = {1'b0, count_q} + (CW+1)'(pend_q);
    assign req  = (state_q == RUN) & fetch_en_i & ~redirect_i &
                  (used < (CW+1)'(DEPTH));
    assign push = pend_q & ~redirect_i;
    assign pop  = (count_q != '0) & ready_i & ~redirect_i;

    assign im_req_o  = req;
    assign im_addr_o = fetch_pc_q;
    assign valid_o   = (count_q != '0);
    assign inst_o    = valid_o ? inst_mem_q[rd_ptr_q] : NOP;
    assign pc_o      = valid_o ? pc_mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_d     = req;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            pend_d     = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req)  fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (push) wr_ptr_d   = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d   = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch FSM: runs while fetching is enabled, parks otherwise. Queue
    // contents and the pending response survive a drop to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= fetch_en_i ? RUN : IDLE;
                RUN:     state_q <= fetch_en_i ? RUN : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (req) pend_pc_q <= fetch_pc_q;
        if (push && !rst_i) begin
            inst_mem_q[wr_ptr_q] <= im_dout_i;
            pc_mem_q[wr_ptr_q]   <= pend_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ready = 1'b0;
    logic [31:0] im_dout = '0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  count;

    // second instance for the address-wrap case
    logic        b_req;
    logic [31:0] b_addr;
    logic [31:0] b_dout = '0;
    logic        b_valid;
    logic [31:0] b_inst;
    logic [31:0] b_pc;
    logic [2:0]  b_count;
    logic        one = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] zero32 = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst), .fetch_en_i(fetch_en),
        .im_req_o(im_req), .im_addr_o(im_addr), .im_dout_i(im_dout),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .valid_o(valid), .ready_i(ready), .inst_o(inst), .pc_o(pc),
        .count_o(count)
    );

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk_i(clk), .rst_i(rst), .fetch_en_i(one),
        .im_req_o(b_req), .im_addr_o(b_addr), .im_dout_i(b_dout),
        .redirect_i(zero), .redirect_pc_i(zero32),
        .valid_o(b_valid), .ready_i(one), .inst_o(b_inst), .pc_o(b_pc),
        .count_o(b_count)
    );

    always @(posedge clk) b_dout <= b_req ? (b_addr | TAG) : 32'hDEAD_BEEF;

    logic [31:0] bq_addr[$];
    logic [31:0] bq_pc[$];
    logic [31:0] bq_inst[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (b_req && bq_addr.size() < 3) bq_addr.push_back(b_addr);
            if (b_valid && bq_pc.size() < 3) begin
                bq_pc.push_back(b_pc);
                bq_inst.push_back(b_inst);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched words plus the fetch state.
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    bit          m_init = 0;
    bit          m_run;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fpc;

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model across the rising edge.
    task automatic step(input bit r, input bit f, input bit rd,
                        input logic [31:0] rpc, input bit rdy);
        bit   exp_req;
        ent_t e;
        rst = r; fetch_en = f; redirect = rd; redirect_pc = rpc; ready = rdy;
        im_dout = m_pend ? (m_pend_pc | TAG) : $urandom;
        #2;
        exp_req = m_run && f && !rd && ((mq.size() + int'(m_pend)) < DEPTH);
        if (m_init) begin
            check("im_req", 64'(im_req), 64'(exp_req));
            if (exp_req) check("im_addr", 64'(im_addr), 64'(m_fpc));
            check("valid", 64'(valid), 64'(mq.size() != 0));
            check("count", 64'(count), 64'(mq.size()));
            check("inst", 64'(inst), 64'(mq.size() != 0 ? mq[0].inst : NOP));
            check("pc", 64'(pc), 64'(mq.size() != 0 ? mq[0].pc : 32'h0));
        end
        @(posedge clk);
        if (r) begin
            m_init = 1; m_run = 0; m_pend = 0; m_fpc = 32'h0; mq.delete();
        end else if (m_init) begin
            if (rd) begin
                mq.delete();
                m_pend = 0;
                m_fpc  = {rpc[31:2], 2'b00};
            end else begin
                if (rdy && mq.size() != 0) void'(mq.pop_front());
                if (m_pend) begin
                    e.inst = im_dout; e.pc = m_pend_pc;
                    mq.push_back(e);
                end
                m_pend = exp_req;
                if (exp_req) begin
                    m_pend_pc = m_fpc;
                    m_fpc     = m_fpc + 32'd4;
                end
            end
            m_run = f;
        end
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        // reset and reset-state outputs
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        rst = 0; #1;
        check("rst_req", 64'(im_req), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_inst", 64'(inst), 64'(NOP));
        check("rst_pc", 64'(pc), 64'(0));
        check("rst_count", 64'(count), 64'(0));

        // streaming with decode always ready
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 1);

        // decode stalled: queue fills to DEPTH and requests stop
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        check("full_count", 64'(count), 64'(4));
        check("full_noreq", 64'(im_req), 64'(0));
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1);

        // redirect with three queued and one response pending
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        check("pre_redir_count", 64'(count), 64'(3));
        step(0, 1, 1, 32'h0000_0103, 0);
        redirect = 0; #1;
        check("redir_count", 64'(count), 64'(0));
        check("redir_valid", 64'(valid), 64'(0));
        check("redir_addr", 64'(im_addr), 64'(32'h100));
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1);

        // reset wins over redirect and fetch enable
        step(1, 1, 1, 32'h0000_4000, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);

        // fetch enable dropped right after a request
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 15) == 0),
                 $urandom,
                 ($urandom_range(0, 1) == 1));
        end

        // wrap-around instance: first three addresses and head PCs
        check("wrap_nreq", 64'(bq_addr.size()), 64'(3));
        check("wrap_npop", 64'(bq_pc.size()), 64'(3));
        if (bq_addr.size() == 3 && bq_pc.size() == 3) begin
            check("wrap_addr0", 64'(bq_addr[0]), 64'(32'hFFFF_FFF8));
            check("wrap_addr1", 64'(bq_addr[1]), 64'(32'hFFFF_FFFC));
            check("wrap_addr2", 64'(bq_addr[2]), 64'(32'h0000_0000));
            check("wrap_pc0", 64'(bq_pc[0]), 64'(32'hFFFF_FFF8));
            check("wrap_pc1", 64'(bq_pc[1]), 64'(32'hFFFF_FFFC));
            check("wrap_pc2", 64'(bq_pc[2]), 64'(32'h0000_0000));
            check("wrap_inst2", 64'(bq_inst[2]), 64'(TAG));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
